// File: rtl/out_port_uart_tx_if.sv
// Output-port write channel from the core to the serial transmit stage.
//   out_data : byte written by the core's OUT instruction
//   out_we   : one-cycle strobe qualifying out_data
// Modports: master (core side, drives), slave (transmitter side, receives).
interface out_port_uart_tx_if;
    logic [7:0] out_data;
    logic       out_we;

    modport master (output out_data, output out_we);
    modport slave  (input  out_data, input  out_we);
endinterface

// File: rtl/out_port_uart_tx.sv
// Serial output stage: captures OUT writes into a FIFO and shifts each byte
// out LSB-first as an async frame (start, 8 data, [parity], stop) on tx.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   out_port  : write channel (out_data, out_we), slave side
//   tx        : serial line, idles high
//   busy      : frame in progress (FSM not idle)
//   empty     : FIFO holds no entries
//   full      : FIFO holds DEPTH entries
//   count     : FIFO occupancy, 0..DEPTH
//   overflow  : sticky, set when a write is dropped while full
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit after data.
module out_port_uart_tx #(
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    out_port_uart_tx_if.slave       out_port,
    output logic                    tx,
    output logic                    busy,
    output logic                    empty,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TMR_W = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP
`ifdef UART_TX_PARITY_EN
        , PARITY
`endif
    } state_t;

    state_t           state;
    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count_next;
    logic [7:0]       shreg;
    logic [2:0]       bit_idx;
    logic [TMR_W-1:0] tmr;
    logic             tmr_last;
    logic             push;
    logic             pop;
`ifdef UART_TX_PARITY_EN
    logic             par;
`endif

    // Push uses the pre-edge full flag, so a pop on the same edge cannot make room.
    assign push     = out_port.out_we && !full;
    assign tmr_last = (tmr == TMR_W'(CLKS_PER_BIT - 1));
    // Head is consumed when leaving IDLE or when a stop bit ends with more data queued.
    assign pop      = !empty && ((state == IDLE) || ((state == STOP) && tmr_last));

    // Occupancy update
    always_comb begin
        count_next = count;
        unique case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // FIFO storage (no reset needed, validity tracked by count)
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= out_port.out_data;
    end

    // FIFO pointers, flags and sticky overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_next;
            empty <= (count_next == '0);
            full  <= (count_next == CNT_W'(DEPTH));
            if (out_port.out_we && full) overflow <= 1'b1;
        end
    end

    // Transmit FSM with registered tx/busy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            tx      <= 1'b1;
            busy    <= 1'b0;
            shreg   <= '0;
            bit_idx <= '0;
            tmr     <= '0;
`ifdef UART_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            tmr <= tmr_last ? '0 : tmr + TMR_W'(1);
            if (pop) begin
                state <= START;
                tx    <= 1'b0;
                busy  <= 1'b1;
                shreg <= mem[rd_ptr];
                tmr   <= '0;
`ifdef UART_TX_PARITY_EN
                par   <= ^mem[rd_ptr];
`endif
            end else begin
                case (state)
                    IDLE: begin
                        tx   <= 1'b1;
                        busy <= 1'b0;
                        tmr  <= '0;
                    end
                    START: begin
                        if (tmr_last) begin
                            state   <= DATA;
                            bit_idx <= '0;
                            tx      <= shreg[0];
                        end
                    end
                    DATA: begin
                        if (tmr_last) begin
                            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                                state <= PARITY;
                                tx    <= par;
`else
                                state <= STOP;
                                tx    <= 1'b1;
`endif
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                                tx      <= shreg[bit_idx + 3'd1];
                            end
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    PARITY: begin
                        if (tmr_last) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end
                    end
`endif
                    STOP: begin
                        // Queued data is handled by the pop branch above.
                        if (tmr_last) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        tx    <= 1'b1;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_out_port_uart_tx.sv
// Directed bench for out_port_uart_tx at DEPTH=4, CLKS_PER_BIT=4.
// A line monitor decodes frames from tx into queues; the directed sequence
// checks exact timing and the decoded bytes against hand-computed values.
module tb_out_port_uart_tx;
    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tx, busy, empty, full, overflow;
    logic [2:0] count;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;

    logic [7:0] rx_q [$];
    logic       rx_par_q [$];
    logic       rx_stop_q [$];
    int         rx_t0_q [$];

    out_port_uart_tx_if ifc ();

    out_port_uart_tx #(.DEPTH(4), .CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .rst      (rst),
        .out_port (ifc),
        .tx       (tx),
        .busy     (busy),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write(input logic [7:0] d);
        ifc.out_data = d;
        ifc.out_we   = 1'b1;
        tick();
        ifc.out_we   = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget);
        int k;
        k = 0;
        while (rx_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        check("rx_count", rx_q.size(), n);
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while ((busy || !empty) && k < budget) begin
            tick();
            k++;
        end
        check("idle", {busy, empty}, 2'b01);
    endtask

    // Line monitor: samples mid-bit after each detected start edge
    initial begin : monitor
        logic [7:0] b;
        logic       p, ok, stop_ok;
        int         t0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && tx === 1'b0) begin
                t0 = cyc;
                ok = 1'b1;
                b  = '0;
                p  = 1'b0;
                repeat (CPB / 2) @(posedge clk);
                #1;
                if (rst || tx !== 1'b0) ok = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(posedge clk);
                    #1;
                    if (rst) ok = 1'b0;
                    b[i] = tx;
                end
`ifdef UART_TX_PARITY_EN
                repeat (CPB) @(posedge clk);
                #1;
                if (rst) ok = 1'b0;
                p = tx;
`endif
                repeat (CPB) @(posedge clk);
                #1;
                if (rst) ok = 1'b0;
                stop_ok = (tx === 1'b1);
                if (ok) begin
                    rx_q.push_back(b);
                    rx_par_q.push_back(p);
                    rx_stop_q.push_back(stop_ok);
                    rx_t0_q.push_back(t0);
                end
            end
        end
    end

    initial begin : stim
        logic exp_bits [0:10];
        int   c1, bad;
        logic [7:0] b;

        ifc.out_data = 8'h00;
        ifc.out_we   = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_count", count, 3'd0);
        check("rst_overflow", overflow, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("idle_tx", tx, 1'b1);

        // Single byte 0xA5, exact bit timing
`ifdef UART_TX_PARITY_EN
        exp_bits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_bits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
`endif
        rx_q.delete(); rx_par_q.delete(); rx_stop_q.delete(); rx_t0_q.delete();
        write(8'hA5);
        check("a5_count_k", count, 3'd1);
        check("a5_tx_k", tx, 1'b1);
        check("a5_busy_k", busy, 1'b0);
        tick();
        check("a5_count_k1", count, 3'd0);
        check("a5_empty_k1", empty, 1'b1);
        for (int j = 0; j < FRAME; j++) begin
            check($sformatf("a5_tx_%0d", j), tx, exp_bits[j / CPB]);
            check($sformatf("a5_busy_%0d", j), busy, 1'b1);
            tick();
        end
        check("a5_busy_end", busy, 1'b0);
        check("a5_tx_end", tx, 1'b1);
        wait_rx(1, 4);
        if (rx_q.size() > 0) check("a5_rx", rx_q[0], 8'hA5);

        // Back-to-back 0x01, 0x02 with no idle gap
        rx_q.delete(); rx_par_q.delete(); rx_stop_q.delete(); rx_t0_q.delete();
        write(8'h01);
        write(8'h02);
        c1 = cyc;
        check("b2b_tx_first", tx, 1'b0);
        check("b2b_count", count, 3'd1);
        repeat (FRAME) tick();
        check("b2b_tx_second", tx, 1'b0);
        check("b2b_empty", empty, 1'b1);
        check("b2b_busy", busy, 1'b1);
        wait_rx(2, 2 * FRAME);
        if (rx_q.size() == 2) begin
            check("b2b_byte0", rx_q[0], 8'h01);
            check("b2b_byte1", rx_q[1], 8'h02);
            check("b2b_t0", rx_t0_q[0], c1);
            check("b2b_gap", rx_t0_q[1] - rx_t0_q[0], FRAME);
            check("b2b_stop0", rx_stop_q[0], 1'b1);
            check("b2b_stop1", rx_stop_q[1], 1'b1);
`ifdef UART_TX_PARITY_EN
            check("b2b_par0", rx_par_q[0], 1'b1);
            check("b2b_par1", rx_par_q[1], 1'b1);
`endif
        end
        wait_idle(2 * FRAME);

        // Overflow: six writes into a 4-deep FIFO
        rx_q.delete(); rx_par_q.delete(); rx_stop_q.delete(); rx_t0_q.delete();
        for (int i = 0; i < 6; i++) begin
            write(8'h10 + 8'(i));
            if (i == 4) begin
                check("ovf_count4", count, 3'd4);
                check("ovf_full", full, 1'b1);
                check("ovf_pre", overflow, 1'b0);
            end
        end
        check("ovf_set", overflow, 1'b1);
        check("ovf_count_hold", count, 3'd4);
        wait_rx(5, 6 * FRAME);
        repeat (2 * FRAME) tick();
        check("ovf_rx_total", rx_q.size(), 5);
        if (rx_q.size() == 5)
            for (int i = 0; i < 5; i++)
                check($sformatf("ovf_byte%0d", i), rx_q[i], 8'h10 + 8'(i));
        check("ovf_sticky", overflow, 1'b1);

        // Reset mid-frame during DATA of 0xFF with a second byte queued
        rx_q.delete(); rx_par_q.delete(); rx_stop_q.delete(); rx_t0_q.delete();
        write(8'hFF);
        write(8'h00);
        repeat (12) tick();
        check("rmf_busy_pre", busy, 1'b1);
        check("rmf_count_pre", count, 3'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rmf_tx", tx, 1'b1);
        check("rmf_count", count, 3'd0);
        check("rmf_busy", busy, 1'b0);
        check("rmf_empty", empty, 1'b1);
        check("rmf_overflow", overflow, 1'b0);
        repeat (10) tick();
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (tx !== 1'b1) bad++;
        end
        check("rmf_tx_idle", bad, 0);
        check("rmf_no_rx", rx_q.size(), 0);

        // Parity frame for 0x07
        rx_q.delete(); rx_par_q.delete(); rx_stop_q.delete(); rx_t0_q.delete();
        write(8'h07);
        tick();
        check("p07_busy_start", busy, 1'b1);
        repeat (FRAME - 1) tick();
        check("p07_busy_last", busy, 1'b1);
        tick();
        check("p07_busy_end", busy, 1'b0);
        wait_rx(1, 4);
        if (rx_q.size() == 1) begin
            check("p07_byte", rx_q[0], 8'h07);
            check("p07_stop", rx_stop_q[0], 1'b1);
`ifdef UART_TX_PARITY_EN
            check("p07_parity", rx_par_q[0], 1'b1);
`endif
        end

        // Pointer wrap: 10 bytes in bursts of 3
        rx_q.delete(); rx_par_q.delete(); rx_stop_q.delete(); rx_t0_q.delete();
        for (int i = 0; i < 10; i++) begin
            write(8'h20 + 8'(i));
            if (i % 3 == 2 || i == 9) wait_rx(i + 1, 4 * FRAME + 10);
        end
        check("wrap_total", rx_q.size(), 10);
        for (int i = 0; i < 10; i++) begin
            b = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            check($sformatf("wrap_byte%0d", i), b, 8'h20 + 8'(i));
        end
        check("wrap_overflow", overflow, 1'b0);
        wait_idle(2 * FRAME);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/out_port_uart_tx.md
# out_port_uart_tx

Serial output stage that sits directly downstream of the processor's 8-bit output port. Each OUT write from the core is captured into a small FIFO and shifted out LSB-first as an asynchronous serial frame on a single `tx` line. The FIFO decouples the core's single-cycle port writes from the much slower bit rate, and status flags report occupancy and lost writes.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; ≥2.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `out_data`  in  8: byte from the core's output port.
- `out_we`  in  1: one-cycle write strobe qualifying `out_data`.
- `tx`  out  1: serial line; idles high.
- `busy`  out  1: high whenever the FSM is not in IDLE.
- `empty`  out  1: FIFO holds 0 entries.
- `full`  out  1: FIFO holds DEPTH entries.
- `count`  out  $clog2(DEPTH)+1: current FIFO occupancy.
- `overflow`  out  1: sticky flag, set when a write is dropped; cleared only by `rst`.

## Operation
- FIFO:
  - Circular buffer with read/write pointers and an explicit occupancy counter.
  - Push on `out_we && !full`.
  - `full` is the registered value from before the edge. A push while full is rejected even if a pop happens on the same edge, and `overflow` is set.
  - Simultaneous push and pop leaves `count` unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states are IDLE, START, DATA, PARITY (only with the macro enabled), and STOP.
  - IDLE → START when `!empty`: pop the head into the shift register and drive `tx`=0.
  - START → DATA after CLKS_PER_BIT cycles.
  - DATA shifts 8 bits, LSB first, each held for CLKS_PER_BIT cycles, using a 3-bit bit index.
  - DATA → PARITY (if enabled) → STOP. STOP drives `tx`=1 for CLKS_PER_BIT cycles.
  - At the end of STOP: if `!empty`, pop and go directly to START, with no idle gap. Otherwise go to IDLE.
- The bit timer counts 0..CLKS_PER_BIT-1 and resets at every bit boundary.
- `tx` is registered, so there are no glitches.
- `count` arithmetic is unsigned and never exceeds DEPTH or drops below 0.

## Timing
- Reset values: `tx`=1, `busy`=0, `empty`=1, `full`=0, `count`=0, `overflow`=0. The FSM is in IDLE and the pointers are 0.
- Reset mid-frame clears the FIFO and takes `tx` high immediately, without waiting for a clock. The partial frame is abandoned.
- Write to empty FIFO at posedge k:
  - `count`=1 after edge k.
  - The pop occurs at edge k+1, and `tx`=0 and `busy`=1 from edge k+1.
  - `count` returns to 0 after edge k+1 if there is no new push.
- Frame length is 10·CLKS_PER_BIT cycles, or 11·CLKS_PER_BIT with parity.
- `busy` falls on the edge that ends STOP when the FIFO is empty.
- `overflow` rises on the edge of the rejected write.

## Configuration
- `UART_TX_PARITY_EN`:
  - Defined: a PARITY state follows DATA, transmitting the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Undefined: DATA goes directly to STOP, and no parity logic is synthesized.

## Test plan
- Single byte (CLKS_PER_BIT=4): with macro off, write 0xA5 at edge k.
  - `tx` is low from edge k+1.
  - Bit sequence is 0,1,0,1,0,0,1,0,1,1, each held 4 cycles.
  - `busy` falls at edge k+41.
- Back-to-back: write 0x01 then 0x02 on consecutive cycles.
  - 20 contiguous bit periods, with the second start bit immediately after the first stop bit.
  - `empty`=1 after the second pop.
- Overflow (DEPTH=4): write 0x10–0x15 on six consecutive edges k..k+5.
  - `count` reaches 4 and `full`=1 after k+4.
  - 0x15 is dropped and `overflow`=1 after k+5.
  - Exactly 0x10–0x14 are transmitted.
- Reset mid-frame: assert `rst` during DATA of 0xFF.
  - `tx`=1, `count`=0, `busy`=0 immediately.
  - After release, with no writes, `tx` stays 1.
- Parity (macro on): write 0x07.
  - The bit after data is 1, then the stop bit.
  - Frame lasts 44 cycles at CLKS_PER_BIT=4.
- Wrap: with DEPTH=4, push and drain 10 bytes 0x20–0x29 in bursts of 3.
  - All 10 bytes are received in order.
  - `overflow` stays 0.
